weight_bank_buffer: RTL and testbench

- Parametrised, multi-lane successor to the single-port weight store.
- Weights arrive as a serial byte stream with a valid/ready handshake. An internal load FSM writes them from a programmable base address with an auto-incrementing pointer.
- The conv engine reads LANES consecutive weights per cycle from banked block RAM.
- Sits between the host/DMA weight loader and the MAC array.

---
 rtl/weight_bank_buffer.sv | 172 +++++++++++++++++
 tb/tb_weight_bank_buffer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_bank_buffer.sv
// weight_bank_buffer: banked weight store between the weight loader and the MAC array.
// A serial byte stream (valid/ready) is written from a programmable base address with an
// auto-incrementing pointer. The conv engine reads LANES consecutive words per cycle.
//
// Ports:
//   clk                    system clock, rising edge
//   reset                  synchronous active-low reset
//   ld_start/ld_base/ld_len  load job request (sampled while IDLE)
//   in_data/in_valid/in_ready  weight stream handshake
//   ld_busy/ld_done/ld_err   job status (registered)
//   rd_en/rd_row           row read request
//   rd_data/rd_valid       LANES words, lane 0 = lowest flat address, latency 1
module weight_bank_buffer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 23184,
    parameter int unsigned LANES  = 4,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned ROW_W  = $clog2(DEPTH / LANES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ld_start,
    input  logic [ADDR_W-1:0]       ld_base,
    input  logic [ADDR_W:0]         ld_len,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    ld_busy,
    output logic                    ld_done,
    output logic                    ld_err,
    input  logic                    rd_en,
    input  logic [ROW_W-1:0]        rd_row,
    output logic [LANES*DATA_W-1:0] rd_data,
    output logic                    rd_valid
);

    localparam int unsigned ROWS    = DEPTH / LANES;
    localparam int unsigned LANE_SH = $clog2(LANES);
    localparam int unsigned BANK_W  = (LANES > 1) ? LANE_SH : 1;
    localparam int unsigned LEN_W   = ADDR_W + 1;
    localparam int unsigned SUM_W   = ADDR_W + 2;

    // Parameter sanity checks at elaboration
    if ((DEPTH % LANES) != 0) begin : g_depth_chk
        $error("weight_bank_buffer: DEPTH must be a multiple of LANES");
    end
    if ((LANES == 0) || ((LANES & (LANES - 1)) != 0)) begin : g_lanes_chk
        $error("weight_bank_buffer: LANES must be a power of 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               in_ready_d, ld_busy_d, ld_done_d, ld_err_d;
    logic [SUM_W-1:0]   job_end;
    logic               wr_en;
    logic [BANK_W-1:0]  wr_bank;
    logic [ROW_W-1:0]   wr_row;

    // End address widened so base+len can never wrap in the bounds check
    assign job_end = SUM_W'(ld_base) + SUM_W'(ld_len);

    // Handshake gated by reset so an aborting edge writes nothing
    assign wr_en   = in_valid && in_ready && reset;

    // Bank = low address bits, row = remaining bits; no divider
    assign wr_bank = BANK_W'(ptr_q & ADDR_W'(LANES - 1));
    assign wr_row  = ROW_W'(ptr_q >> LANE_SH);

    // Load FSM: state, pointer, counter and status flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            rem_q    <= '0;
            in_ready <= 1'b0;
            ld_busy  <= 1'b0;
            ld_done  <= 1'b0;
            ld_err   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            rem_q    <= rem_d;
            in_ready <= in_ready_d;
            ld_busy  <= ld_busy_d;
            ld_done  <= ld_done_d;
            ld_err   <= ld_err_d;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        ld_done_d = 1'b0;
        ld_err_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (ld_start) begin
                    if (ld_len == '0) begin
                        ld_done_d = 1'b1;
                    end else if (job_end > SUM_W'(DEPTH)) begin
                        ld_err_d = 1'b1;
                    end else begin
                        ptr_d   = ld_base;
                        rem_d   = ld_len;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (wr_en) begin
                    ptr_d = ptr_q + ADDR_W'(1);
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d   = ST_DONE;
                        ld_done_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d = (state_d == ST_LOAD);
        ld_busy_d  = (state_d != ST_IDLE);
    end

    // Read valid tracks rd_en with one cycle of latency
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
        end
    end

    // One RAM per lane; read-first on a same-row collision
    for (genvar b = 0; b < LANES; b++) begin : g_bank
        logic [DATA_W-1:0] mem [ROWS];
        logic [DATA_W-1:0] lane_q;

        always_ff @(posedge clk) begin
            if (wr_en && (wr_bank == BANK_W'(b))) begin
                mem[wr_row] <= in_data;
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                lane_q <= '0;
            end else if (rd_en) begin
                lane_q <= mem[rd_row];
            end
        end

        assign rd_data[b*DATA_W +: DATA_W] = lane_q;
    end

endmodule

// File: tb/tb_weight_bank_buffer.sv
// Scoreboard bench for weight_bank_buffer: a byte-level memory model is updated on each
// observed handshake; read expectations are queued at issue and compared on rd_valid.
module tb_weight_bank_buffer;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 23184;
    localparam int unsigned LANES  = 4;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned ROW_W  = 13;

    logic                    clk;
    logic                    reset;
    logic                    ld_start;
    logic [ADDR_W-1:0]       ld_base;
    logic [ADDR_W:0]         ld_len;
    logic [DATA_W-1:0]       in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic                    ld_busy;
    logic                    ld_done;
    logic                    ld_err;
    logic                    rd_en;
    logic [ROW_W-1:0]        rd_row;
    logic [LANES*DATA_W-1:0] rd_data;
    logic                    rd_valid;

    weight_bank_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LANES  (LANES),
        .ADDR_W (ADDR_W),
        .ROW_W  (ROW_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ld_start (ld_start),
        .ld_base  (ld_base),
        .ld_len   (ld_len),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ld_busy  (ld_busy),
        .ld_done  (ld_done),
        .ld_err   (ld_err),
        .rd_en    (rd_en),
        .rd_row   (rd_row),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [LANES*DATA_W-1:0] exp;
        logic [LANES*DATA_W-1:0] mask;
        int                      due;
    } sb_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   m_ptr  = 0;
    int   hs_cnt = 0;
    sb_t  sb [$];
    sb_t  e;
    logic [DATA_W-1:0] model [DEPTH];
    bit                known [DEPTH];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Memory model follows every accepted handshake
    always @(posedge clk) begin
        if (reset && in_valid && in_ready) begin
            if (m_ptr >= 0 && m_ptr < int'(DEPTH)) begin
                model[m_ptr] = in_data;
                known[m_ptr] = 1'b1;
            end
            m_ptr++;
            hs_cnt++;
        end
    end

    // Read response checker
    always @(negedge clk) begin
        if (rd_valid) begin
            if (sb.size() == 0) begin
                check("rd_extra", 1, 0);
            end else begin
                e = sb.pop_front();
                check("rd_lat", cyc, e.due);
                check("rd_data", rd_data & e.mask, e.exp);
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            check("rd_miss", 0, 1);
            e = sb.pop_front();
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int base, input int len);
        ld_start = 1'b1;
        ld_base  = ADDR_W'(base);
        ld_len   = (ADDR_W+1)'(len);
        m_ptr    = base;
        hs_cnt   = 0;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            check("rdy_timeout", in_ready, 1);
            return;
        end
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic finish_job(input string tag, input int nexp);
        check({tag, "_done"}, ld_done, 1);
        check({tag, "_busy"}, ld_busy, 1);
        check({tag, "_rdy"}, in_ready, 0);
        check({tag, "_hs"}, hs_cnt, nexp);
        tick();
        check({tag, "_done_off"}, ld_done, 0);
        check({tag, "_busy_off"}, ld_busy, 0);
    endtask

    task automatic rd_req(input int row);
        sb_t s;
        int  a;
        s.exp  = '0;
        s.mask = '0;
        s.due  = cyc + 1;
        for (int k = 0; k < int'(LANES); k++) begin
            a = row * int'(LANES) + k;
            if (a < int'(DEPTH) && known[a]) begin
                s.exp[k*DATA_W +: DATA_W]  = model[a];
                s.mask[k*DATA_W +: DATA_W] = '1;
            end
        end
        sb.push_back(s);
        rd_en  = 1'b1;
        rd_row = ROW_W'(row);
    endtask

    task automatic do_read(input int row);
        rd_req(row);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_rdy"}, in_ready, 0);
        check({tag, "_busy"}, ld_busy, 0);
        check({tag, "_rdv"}, rd_valid, 0);
        check({tag, "_rdd"}, rd_data, 0);
    endtask

    initial begin
        reset    = 1'b0;
        ld_start = 1'b0;
        ld_base  = '0;
        ld_len   = '0;
        in_data  = '0;
        in_valid = 1'b0;
        rd_en    = 1'b0;
        rd_row   = '0;

        // Reset and idle
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle("rst");
            check("rst_done", ld_done, 0);
            check("rst_err", ld_err, 0);
        end
        reset = 1'b1;
        tick();
        chk_idle("idle");

        // Basic job with backpressure
        start_job(0, 8);
        check("basic_rdy_on", in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            send_word(8'(8'h10 + i));
            if (i < 7) tick();
        end
        finish_job("basic", 8);
        do_read(0);
        do_read(1);
        tick();
        tick();
        check("rd_idle", rd_valid, 0);
        check("rd_hold", rd_data, 32'h17161514);

        // Unaligned base
        start_job(6, 3);
        send_word(8'hA0);
        send_word(8'hA1);
        send_word(8'hA2);
        finish_job("unal", 3);
        do_read(1);
        do_read(2);

        // Last row, exactly in bounds
        start_job(23180, 4);
        for (int i = 0; i < 4; i++) send_word(8'(8'hC0 + i));
        finish_job("top", 4);
        do_read(5795);

        // Out of bounds by one word
        start_job(23180, 5);
        check("oob_err", ld_err, 1);
        check("oob_rdy", in_ready, 0);
        check("oob_busy", ld_busy, 0);
        check("oob_done", ld_done, 0);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("oob_err_off", ld_err, 0);
            check("oob_rdy_off", in_ready, 0);
        end
        in_valid = 1'b0;
        check("oob_hs", hs_cnt, 0);
        do_read(5795);

        // Zero length
        start_job(40, 0);
        check("zero_done", ld_done, 1);
        check("zero_busy", ld_busy, 0);
        check("zero_rdy", in_ready, 0);
        tick();
        check("zero_done_off", ld_done, 0);

        // Read/write collision on row 2 lane 0
        start_job(8, 1);
        check("col_rdy", in_ready, 1);
        in_valid = 1'b1;
        in_data  = 8'h55;
        rd_req(2);
        tick();
        in_valid = 1'b0;
        check("col_done", ld_done, 1);
        check("col_hs", hs_cnt, 1);
        rd_req(2);
        tick();
        rd_en = 1'b0;
        check("col_done_off", ld_done, 0);
        check("col_busy_off", ld_busy, 0);

        // Reset in the middle of a job
        start_job(16, 8);
        send_word(8'hB0);
        send_word(8'hB1);
        send_word(8'hB2);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("mid_done", ld_done, 0);
            check("mid_busy", ld_busy, 0);
            check("mid_rdy", in_ready, 0);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_done_post", ld_done, 0);
            check("mid_rdy_post", in_ready, 0);
        end
        check("mid_hs", hs_cnt, 3);
        do_read(4);

        // ld_start during LOAD and DONE is ignored
        start_job(32, 4);
        send_word(8'hD0);
        ld_start = 1'b1;
        ld_base  = ADDR_W'(100);
        ld_len   = (ADDR_W+1)'(2);
        tick();
        ld_start = 1'b0;
        check("ign_rdy", in_ready, 1);
        send_word(8'hD1);
        send_word(8'hD2);
        send_word(8'hD3);
        check("ign_done", ld_done, 1);
        check("ign_hs", hs_cnt, 4);
        ld_start = 1'b1;
        ld_base  = ADDR_W'(200);
        ld_len   = (ADDR_W+1)'(1);
        tick();
        ld_start = 1'b0;
        check("ign_done_off", ld_done, 0);
        check("ign_busy_off", ld_busy, 0);
        check("ign_rdy_off", in_ready, 0);
        do_read(8);

        for (int i = 0; i < 3; i++) tick();
        check("sb_drain", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
